// File: rtl/axil_rd_router.sv
// axil_rd_router
//
// Routes reads from one AXI4-Lite master to one of NUM_SLV AXI4-Lite slaves,
// chosen by address decode. At most one read is in flight at a time. A read
// that matches no slave window gets a local DECERR response, and the
// saturating decerr_cnt counts it.
//
// Ports
//   aclk, areset          : clock, synchronous active-high reset
//   s_axil_ar*            : upstream read-address channel (from the master)
//   s_axil_r*             : upstream read-data channel (to the master)
//   m_axil_ar*[NUM_SLV]   : downstream read-address channels (to the slaves)
//   m_axil_r*[NUM_SLV]    : downstream read-data channels (from the slaves)
//   busy                  : high whenever a read is in progress
//   decerr_cnt            : saturating count of decode-error reads
//
// While areset is high, every output is held at 0.

module axil_rd_router #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int NUM_SLV        = 4,
    // Slave i has base i<<12 by default. The 16-entry table is truncated
    // down to the NUM_SLV entries that are actually present.
    parameter logic [NUM_SLV-1:0][AXI_ADDR_WIDTH-1:0] SLV_BASE =
        (NUM_SLV*AXI_ADDR_WIDTH)'({
            AXI_ADDR_WIDTH'(32'h0000_F000), AXI_ADDR_WIDTH'(32'h0000_E000),
            AXI_ADDR_WIDTH'(32'h0000_D000), AXI_ADDR_WIDTH'(32'h0000_C000),
            AXI_ADDR_WIDTH'(32'h0000_B000), AXI_ADDR_WIDTH'(32'h0000_A000),
            AXI_ADDR_WIDTH'(32'h0000_9000), AXI_ADDR_WIDTH'(32'h0000_8000),
            AXI_ADDR_WIDTH'(32'h0000_7000), AXI_ADDR_WIDTH'(32'h0000_6000),
            AXI_ADDR_WIDTH'(32'h0000_5000), AXI_ADDR_WIDTH'(32'h0000_4000),
            AXI_ADDR_WIDTH'(32'h0000_3000), AXI_ADDR_WIDTH'(32'h0000_2000),
            AXI_ADDR_WIDTH'(32'h0000_1000), AXI_ADDR_WIDTH'(32'h0000_0000)}),
    parameter logic [NUM_SLV-1:0][AXI_ADDR_WIDTH-1:0] SLV_MASK =
        {NUM_SLV{AXI_ADDR_WIDTH'(32'hFFFF_F000)}}
) (
    input  logic                                     aclk,
    input  logic                                     areset,

    input  logic [AXI_ADDR_WIDTH-1:0]                s_axil_araddr,
    input  logic                                     s_axil_arvalid,
    output logic                                     s_axil_arready,

    output logic [AXI_DATA_WIDTH-1:0]                s_axil_rdata,
    output logic [1:0]                               s_axil_rresp,
    output logic                                     s_axil_rvalid,
    input  logic                                     s_axil_rready,

    output logic [NUM_SLV-1:0][AXI_ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic [NUM_SLV-1:0]                       m_axil_arvalid,
    input  logic [NUM_SLV-1:0]                       m_axil_arready,

    input  logic [NUM_SLV-1:0][AXI_DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [NUM_SLV-1:0][1:0]                  m_axil_rresp,
    input  logic [NUM_SLV-1:0]                       m_axil_rvalid,
    output logic [NUM_SLV-1:0]                       m_axil_rready,

    output logic                                     busy,
    output logic [15:0]                              decerr_cnt
);

    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SLV_AR,
        SLV_R,
        ERR_R
    } state_t;

    state_t                     state_q, state_d;
    logic [SEL_W-1:0]           sel_q, sel_d;
    logic [AXI_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [15:0]                cnt_q, cnt_d;

    logic                       dec_hit;
    logic [SEL_W-1:0]           dec_idx;

    // The loop runs from the highest index down, so the lowest matching
    // index is written last and wins when windows overlap. With
    // NUM_SLV = 1, the only possible index is 0.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((s_axil_araddr & SLV_MASK[i]) == SLV_BASE[i]) begin
                dec_hit = 1'b1;
                dec_idx = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and all outputs. In SLV_R the upstream response is a
    // combinational pass-through of the selected slave, which is why a
    // zero-wait slave completes in 3 cycles. The final reset override
    // forces every output to 0 even in the cycle before the registers
    // are cleared.
    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;

        s_axil_arready = 1'b0;
        s_axil_rdata   = '0;
        s_axil_rresp   = 2'b00;
        s_axil_rvalid  = 1'b0;
        m_axil_araddr  = {NUM_SLV{addr_q}};
        m_axil_arvalid = '0;
        m_axil_rready  = '0;
        busy           = (state_q != IDLE);
        decerr_cnt     = cnt_q;

        case (state_q)
            IDLE: begin
                s_axil_arready = 1'b1;
                if (s_axil_arvalid) begin
                    addr_d = s_axil_araddr;
                    sel_d  = dec_idx;
                    if (dec_hit) begin
                        state_d = SLV_AR;
                    end else begin
                        state_d = ERR_R;
                        if (cnt_q != 16'hFFFF) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
            end

            SLV_AR: begin
                m_axil_arvalid[sel_q] = 1'b1;
                if (m_axil_arready[sel_q]) begin
                    state_d = SLV_R;
                end
            end

            SLV_R: begin
                s_axil_rvalid        = m_axil_rvalid[sel_q];
                s_axil_rdata         = m_axil_rdata[sel_q];
                s_axil_rresp         = m_axil_rresp[sel_q];
                m_axil_rready[sel_q] = s_axil_rready;
                if (m_axil_rvalid[sel_q] && s_axil_rready) begin
                    state_d = IDLE;
                end
            end

            ERR_R: begin
                s_axil_rvalid = 1'b1;
                s_axil_rresp  = 2'b11;
                if (s_axil_rready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (areset) begin
            s_axil_arready = 1'b0;
            s_axil_rdata   = '0;
            s_axil_rresp   = 2'b00;
            s_axil_rvalid  = 1'b0;
            m_axil_araddr  = '0;
            m_axil_arvalid = '0;
            m_axil_rready  = '0;
            busy           = 1'b0;
            decerr_cnt     = '0;
        end
    end

endmodule

// File: tb/tb_axil_rd_router.sv
// tb_axil_rd_router
//
// Directed bench for axil_rd_router. Each test uses hand-computed expected
// values. Slave 3 is placed on top of slave 0's window so that overlap
// priority can be exercised. Inputs change, and outputs are sampled,
// 1 ns after each rising clock edge.

module tb_axil_rd_router;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NS = 4;

    logic                    aclk;
    logic                    areset;
    logic [AW-1:0]           s_axil_araddr;
    logic                    s_axil_arvalid;
    logic                    s_axil_arready;
    logic [DW-1:0]           s_axil_rdata;
    logic [1:0]              s_axil_rresp;
    logic                    s_axil_rvalid;
    logic                    s_axil_rready;
    logic [NS-1:0][AW-1:0]   m_axil_araddr;
    logic [NS-1:0]           m_axil_arvalid;
    logic [NS-1:0]           m_axil_arready;
    logic [NS-1:0][DW-1:0]   m_axil_rdata;
    logic [NS-1:0][1:0]      m_axil_rresp;
    logic [NS-1:0]           m_axil_rvalid;
    logic [NS-1:0]           m_axil_rready;
    logic                    busy;
    logic [15:0]             decerr_cnt;

    int total;
    int bad;

    axil_rd_router #(
        .AXI_DATA_WIDTH (DW),
        .AXI_ADDR_WIDTH (AW),
        .NUM_SLV        (NS),
        .SLV_BASE       ({32'h0000_0000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
        .SLV_MASK       ({4{32'hFFFF_F000}})
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready),
        .busy           (busy),
        .decerr_cnt     (decerr_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Issue one read address. The AR handshake completes on the next edge.
    task automatic applyStimulus(input logic [AW-1:0] addr);
        s_axil_araddr  = addr;
        s_axil_arvalid = 1'b1;
        #1;
        checkOutput("ar_ready", 64'(s_axil_arready), 64'd1);
        tick();
        s_axil_arvalid = 1'b0;
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_arready"}, 64'(s_axil_arready), 64'd0);
        checkOutput({tag, "_rvalid"},  64'(s_axil_rvalid),  64'd0);
        checkOutput({tag, "_rdata"},   64'(s_axil_rdata),   64'd0);
        checkOutput({tag, "_rresp"},   64'(s_axil_rresp),   64'd0);
        checkOutput({tag, "_marvalid"},64'(m_axil_arvalid), 64'd0);
        checkOutput({tag, "_mrready"}, 64'(m_axil_rready),  64'd0);
        checkOutput({tag, "_maraddr"}, 64'(|m_axil_araddr), 64'd0);
        checkOutput({tag, "_busy"},    64'(busy),           64'd0);
        checkOutput({tag, "_decerr"},  64'(decerr_cnt),     64'd0);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        areset         = 1'b1;
        s_axil_araddr  = '0;
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b0;
        m_axil_arready = '0;
        m_axil_rdata   = '0;
        m_axil_rresp   = '0;
        m_axil_rvalid  = '0;

        // Reset state. Even with arvalid raised, every output stays 0.
        tick();
        tick();
        s_axil_arvalid = 1'b1;
        #1;
        checkAllZero("reset");
        s_axil_arvalid = 1'b0;
        areset = 1'b0;
        #1;
        checkOutput("idle_arready", 64'(s_axil_arready), 64'd1);
        checkOutput("idle_busy",    64'(busy),           64'd0);

        // Read 0x1004 from slave 1, which returns 0xDEADBEEF with OKAY.
        $display("[TB] slave 1 read");
        applyStimulus(32'h0000_1004);
        checkOutput("s1_marvalid", 64'(m_axil_arvalid),   64'h2);
        checkOutput("s1_maraddr1", 64'(m_axil_araddr[1]), 64'h1004);
        checkOutput("s1_maraddr0", 64'(m_axil_araddr[0]), 64'h1004);
        checkOutput("s1_busy",     64'(busy),             64'd1);
        checkOutput("s1_rvalid_ar",64'(s_axil_rvalid),    64'd0);
        checkOutput("s1_arready",  64'(s_axil_arready),   64'd0);
        m_axil_arready[1] = 1'b1;
        tick();
        m_axil_arready = '0;
        checkOutput("s1_marvalid_r", 64'(m_axil_arvalid), 64'h0);
        m_axil_rvalid[1] = 1'b1;
        m_axil_rdata[1]  = 32'hDEAD_BEEF;
        m_axil_rresp[1]  = 2'b00;
        s_axil_rready    = 1'b1;
        #1;
        checkOutput("s1_rvalid",  64'(s_axil_rvalid), 64'd1);
        checkOutput("s1_rdata",   64'(s_axil_rdata),  64'hDEAD_BEEF);
        checkOutput("s1_rresp",   64'(s_axil_rresp),  64'd0);
        checkOutput("s1_mrready", 64'(m_axil_rready), 64'h2);
        tick();
        m_axil_rvalid = '0;
        s_axil_rready = 1'b0;
        #1;
        checkOutput("s1_done_busy",   64'(busy),           64'd0);
        checkOutput("s1_done_rvalid", 64'(s_axil_rvalid),  64'd0);
        checkOutput("s1_done_arrdy",  64'(s_axil_arready), 64'd1);

        // Unmapped read. DECERR is presented the cycle after AR acceptance,
        // with no downstream activity.
        $display("[TB] decode error");
        applyStimulus(32'h0009_0000);
        checkOutput("de_rvalid",   64'(s_axil_rvalid),  64'd1);
        checkOutput("de_rresp",    64'(s_axil_rresp),   64'd3);
        checkOutput("de_rdata",    64'(s_axil_rdata),   64'd0);
        checkOutput("de_cnt",      64'(decerr_cnt),     64'd1);
        checkOutput("de_marvalid", 64'(m_axil_arvalid), 64'd0);
        checkOutput("de_busy",     64'(busy),           64'd1);
        s_axil_rready = 1'b1;
        tick();
        s_axil_rready = 1'b0;
        #1;
        checkOutput("de_done_busy",   64'(busy),           64'd0);
        checkOutput("de_done_rvalid", 64'(s_axil_rvalid),  64'd0);
        checkOutput("de_done_mar",    64'(m_axil_arvalid), 64'd0);

        // Slave 2 holds arready off for 5 cycles, then the master holds
        // rready off for 3 cycles. Address and response must stay stable.
        $display("[TB] slave 2 back-pressure");
        applyStimulus(32'h0000_2008);
        for (int i = 0; i < 5; i++) begin
            checkOutput("s2_ar_hold_valid", 64'(m_axil_arvalid),   64'h4);
            checkOutput("s2_ar_hold_addr",  64'(m_axil_araddr[2]), 64'h2008);
            tick();
        end
        m_axil_arready[2] = 1'b1;
        #1;
        checkOutput("s2_ar_last", 64'(m_axil_arvalid), 64'h4);
        tick();
        m_axil_arready   = '0;
        m_axil_rvalid[2] = 1'b1;
        m_axil_rdata[2]  = 32'h1234_5678;
        m_axil_rresp[2]  = 2'b01;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("s2_r_hold_valid", 64'(s_axil_rvalid), 64'd1);
            checkOutput("s2_r_hold_data",  64'(s_axil_rdata),  64'h1234_5678);
            checkOutput("s2_r_hold_resp",  64'(s_axil_rresp),  64'd1);
            checkOutput("s2_r_hold_busy",  64'(busy),          64'd1);
            checkOutput("s2_r_hold_rrdy",  64'(m_axil_rready), 64'h0);
            tick();
        end
        s_axil_rready = 1'b1;
        #1;
        checkOutput("s2_rrdy", 64'(m_axil_rready), 64'h4);
        tick();
        s_axil_rready = 1'b0;
        m_axil_rvalid = '0;
        #1;
        checkOutput("s2_done_busy", 64'(busy), 64'd0);
        tick();
        checkOutput("s2_single_mar",  64'(m_axil_arvalid), 64'd0);
        checkOutput("s2_single_busy", 64'(busy),           64'd0);

        // 0x10 falls in both slave 0 and slave 3; slave 0 must win.
        $display("[TB] overlap priority");
        applyStimulus(32'h0000_0010);
        checkOutput("ov_marvalid", 64'(m_axil_arvalid), 64'h1);
        m_axil_arready[0] = 1'b1;
        tick();
        m_axil_arready   = '0;
        m_axil_rvalid[0] = 1'b1;
        m_axil_rvalid[3] = 1'b1;
        m_axil_rdata[0]  = 32'hAAAA_0000;
        m_axil_rdata[3]  = 32'hBBBB_3333;
        s_axil_rready    = 1'b1;
        #1;
        checkOutput("ov_rdata",   64'(s_axil_rdata),  64'hAAAA_0000);
        checkOutput("ov_mrready", 64'(m_axil_rready), 64'h1);
        tick();
        m_axil_rvalid = '0;
        s_axil_rready = 1'b0;
        #1;
        checkOutput("ov_done_busy", 64'(busy), 64'd0);

        // Reset asserted while in SLV_R: the read is dropped and no stale
        // response appears afterwards.
        $display("[TB] reset mid-transaction");
        applyStimulus(32'h0000_1000);
        m_axil_arready[1] = 1'b1;
        tick();
        m_axil_arready   = '0;
        m_axil_rvalid[1] = 1'b1;
        m_axil_rdata[1]  = 32'hCAFE_0001;
        #1;
        checkOutput("mr_pre_rvalid", 64'(s_axil_rvalid), 64'd1);
        areset = 1'b1;
        #1;
        checkAllZero("mr_rst_now");
        tick();
        checkAllZero("mr_rst_edge");
        areset = 1'b0;
        #1;
        checkOutput("mr_post_rvalid", 64'(s_axil_rvalid),  64'd0);
        checkOutput("mr_post_busy",   64'(busy),           64'd0);
        checkOutput("mr_post_arrdy",  64'(s_axil_arready), 64'd1);
        checkOutput("mr_post_cnt",    64'(decerr_cnt),     64'd0);
        tick();
        checkOutput("mr_post2_rvalid", 64'(s_axil_rvalid), 64'd0);
        checkOutput("mr_post2_mrrdy",  64'(m_axil_rready), 64'd0);
        m_axil_rvalid = '0;

        // Back-to-back unmapped reads take 2 cycles each. The count must
        // reach 0xFFFF and then hold there.
        $display("[TB] decerr saturation");
        s_axil_araddr  = 32'h0009_0000;
        s_axil_arvalid = 1'b1;
        s_axil_rready  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            tick();
        end
        checkOutput("sat_cnt_100", 64'(decerr_cnt), 64'd100);
        for (int i = 100; i < 65534; i++) begin
            tick();
            tick();
        end
        checkOutput("sat_cnt_fffe", 64'(decerr_cnt), 64'hFFFE);
        for (int i = 0; i < 6; i++) begin
            tick();
            tick();
        end
        checkOutput("sat_cnt_ffff", 64'(decerr_cnt), 64'hFFFF);
        s_axil_arvalid = 1'b0;
        tick();
        tick();
        checkOutput("sat_hold",      64'(decerr_cnt), 64'hFFFF);
        checkOutput("sat_idle_busy", 64'(busy),       64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
